// File: rtl/rs232_pkg.sv
// Definitions shared by the RS232 transmitter and receiver: FSM state encoding
// and the default bit period, so both ends of the link agree.
package rs232_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } rs232_state_t;

  localparam logic [15:0] RS232_DEFAULT_BAUD = 16'h28B0;

endpackage

// File: rtl/rs232_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial input; resets to the idle
// (high) line level so a reset never looks like a start bit.
module rs232_rx_sync (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout
);

  logic meta_reg;
  logic sync_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_reg <= 1'b1;
      sync_reg <= 1'b1;
    end else begin
      meta_reg <= din;
      sync_reg <= meta_reg;
    end
  end

  assign dout = sync_reg;

endmodule

// File: rtl/rs232_rx_nbytes.sv
// RS232 receiver: samples 8N1-style frames mid-bit and reassembles n bytes of
// N bits into one packet word, flagging each byte, packet completion and framing errors.
module rs232_rx_nbytes
  import rs232_pkg::*;
#(
  parameter int          n         = 8,
  parameter int          N         = 8,
  parameter int          mlb       = 0,
  parameter logic [15:0] BAUD_RATE = RS232_DEFAULT_BAUD
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           Rs232_Rxd,
  output logic [N*n-1:0] data_out,
  output logic [N-1:0]   rx_byte,
  output logic           rx_byte_valid,
  output logic           rx_done_flag,
  output logic           frame_error,
  output logic           rx_busy
);

  localparam int BYTE_W = (n > 1) ? $clog2(n) : 1;
  localparam int BIT_W  = (N > 1) ? $clog2(N) : 1;

  localparam logic [15:0]       BAUD_LAST = BAUD_RATE - 16'd1;
  localparam logic [15:0]       HALF_LAST = (BAUD_RATE >> 1) - 16'd1;
  localparam logic [BIT_W-1:0]  BIT_FIRST = (mlb != 0) ? '0 : BIT_W'(N - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = (mlb != 0) ? BIT_W'(N - 1) : '0;
  localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(n - 1);

  logic rxd_s;

  rs232_rx_sync u_sync (
    .clk   (clk),
    .reset (reset),
    .din   (Rs232_Rxd),
    .dout  (rxd_s)
  );

  rs232_state_t      state_reg;
  logic [15:0]       clk_count_reg;
  logic [BIT_W-1:0]  bit_idx_reg;
  logic [BYTE_W-1:0] byte_idx_reg;
  logic [N-1:0]      shift_reg;
  logic [N*n-1:0]    pkt_reg;
  logic [N*n-1:0]    data_out_reg;
  logic [N-1:0]      rx_byte_reg;
  logic              rx_byte_valid_reg;
  logic              rx_done_reg;
  logic              frame_error_reg;
  logic [N*n-1:0]    assembled;

  // Partial packet with the byte just shifted in dropped into its slot;
  // the first byte of a packet occupies the most significant slot.
  always_comb begin
    assembled = pkt_reg;
    assembled[(BYTE_LAST - byte_idx_reg) * N +: N] = shift_reg;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg         <= IDLE;
      clk_count_reg     <= '0;
      bit_idx_reg       <= '0;
      byte_idx_reg      <= '0;
      shift_reg         <= '0;
      pkt_reg           <= '0;
      data_out_reg      <= '0;
      rx_byte_reg       <= '0;
      rx_byte_valid_reg <= 1'b0;
      rx_done_reg       <= 1'b0;
      frame_error_reg   <= 1'b0;
    end else begin
      rx_byte_valid_reg <= 1'b0;
      rx_done_reg       <= 1'b0;
      frame_error_reg   <= 1'b0;

      case (state_reg)
        IDLE: begin
          clk_count_reg <= '0;
          if (!rxd_s) state_reg <= START;
        end

        // Re-check the start bit at its midpoint to reject short glitches.
        START: begin
          if (clk_count_reg == HALF_LAST) begin
            clk_count_reg <= '0;
            if (!rxd_s) begin
              state_reg   <= DATA;
              bit_idx_reg <= BIT_FIRST;
            end else begin
              state_reg <= IDLE;
            end
          end else begin
            clk_count_reg <= clk_count_reg + 16'd1;
          end
        end

        DATA: begin
          if (clk_count_reg == BAUD_LAST) begin
            clk_count_reg          <= '0;
            shift_reg[bit_idx_reg] <= rxd_s;
            if (bit_idx_reg == BIT_LAST) begin
              state_reg <= STOP;
            end else if (mlb != 0) begin
              bit_idx_reg <= bit_idx_reg + 1'b1;
            end else begin
              bit_idx_reg <= bit_idx_reg - 1'b1;
            end
          end else begin
            clk_count_reg <= clk_count_reg + 16'd1;
          end
        end

        STOP: begin
          if (clk_count_reg == BAUD_LAST) begin
            clk_count_reg <= '0;
            if (rxd_s) begin
              rx_byte_reg       <= shift_reg;
              rx_byte_valid_reg <= 1'b1;
              pkt_reg           <= assembled;
              state_reg         <= IDLE;
              if (byte_idx_reg == BYTE_LAST) begin
                data_out_reg <= assembled;
                rx_done_reg  <= 1'b1;
                byte_idx_reg <= '0;
              end else begin
                byte_idx_reg <= byte_idx_reg + 1'b1;
              end
            end else begin
              frame_error_reg <= 1'b1;
              byte_idx_reg    <= '0;
              state_reg       <= WAIT_HIGH;
            end
          end else begin
            clk_count_reg <= clk_count_reg + 16'd1;
          end
        end

        // A low stop bit may be a break; wait for the line to return idle.
        WAIT_HIGH: begin
          clk_count_reg <= '0;
          if (rxd_s) state_reg <= IDLE;
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

  assign data_out      = data_out_reg;
  assign rx_byte       = rx_byte_reg;
  assign rx_byte_valid = rx_byte_valid_reg;
  assign rx_done_flag  = rx_done_reg;
  assign frame_error   = frame_error_reg;
  assign rx_busy       = (state_reg != IDLE);

endmodule

// File: tb/tb_rs232_rx_nbytes.sv
// Bench for rs232_rx_nbytes: one MSB-first and one LSB-first receiver share the
// same serial line; a queue-based packet model predicts every pulse of both.
module tb_rs232_rx_nbytes;

  localparam int BAUD = 16;
  localparam int NB   = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic rxd = 1'b1;

  logic [31:0] data_out0, data_out1;
  logic [7:0]  rx_byte0, rx_byte1;
  logic        v0, v1, d0, d1, fe0, fe1, busy0, busy1;

  rs232_rx_nbytes #(.n(NB), .N(8), .mlb(0), .BAUD_RATE(16'd16)) dut_msb (
    .clk(clk), .reset(reset), .Rs232_Rxd(rxd), .data_out(data_out0), .rx_byte(rx_byte0),
    .rx_byte_valid(v0), .rx_done_flag(d0), .frame_error(fe0), .rx_busy(busy0)
  );

  rs232_rx_nbytes #(.n(NB), .N(8), .mlb(1), .BAUD_RATE(16'd16)) dut_lsb (
    .clk(clk), .reset(reset), .Rs232_Rxd(rxd), .data_out(data_out1), .rx_byte(rx_byte1),
    .rx_byte_valid(v1), .rx_done_flag(d1), .frame_error(fe1), .rx_busy(busy1)
  );

  always #5 clk = ~clk;

  // kind: 0 = byte pulse, 1 = packet done, 2 = frame error
  typedef struct {
    int          dut;
    int          kind;
    logic [31:0] val;
  } ev_t;

  ev_t        got_q[$];
  ev_t        exp_q[$];
  int         got_rd = 0;
  int         vectors = 0;
  int         errors = 0;
  logic [7:0] pkt0[$];
  logic [7:0] pkt1[$];

  function automatic ev_t mk_ev(input int dut, input int kind, input logic [31:0] val);
    ev_t e;
    e.dut  = dut;
    e.kind = kind;
    e.val  = val;
    return e;
  endfunction

  always @(negedge clk) begin
    if (v0)  got_q.push_back(mk_ev(0, 0, {24'h0, rx_byte0}));
    if (d0)  got_q.push_back(mk_ev(0, 1, data_out0));
    if (fe0) got_q.push_back(mk_ev(0, 2, 32'h0));
    if (v1)  got_q.push_back(mk_ev(1, 0, {24'h0, rx_byte1}));
    if (d1)  got_q.push_back(mk_ev(1, 1, data_out1));
    if (fe1) got_q.push_back(mk_ev(1, 2, 32'h0));
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [7:0] rev8(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = v[7-i];
    return r;
  endfunction

  // The line carries v MSB first; an LSB-first receiver therefore sees rev8(v).
  task automatic model_good(input logic [7:0] v);
    logic [31:0] w;
    exp_q.push_back(mk_ev(0, 0, {24'h0, v}));
    pkt0.push_back(v);
    if (pkt0.size() == NB) begin
      w = 0;
      foreach (pkt0[i]) w = {w[23:0], pkt0[i]};
      exp_q.push_back(mk_ev(0, 1, w));
      pkt0.delete();
    end
    exp_q.push_back(mk_ev(1, 0, {24'h0, rev8(v)}));
    pkt1.push_back(rev8(v));
    if (pkt1.size() == NB) begin
      w = 0;
      foreach (pkt1[i]) w = {w[23:0], pkt1[i]};
      exp_q.push_back(mk_ev(1, 1, w));
      pkt1.delete();
    end
  endtask

  task automatic model_bad();
    exp_q.push_back(mk_ev(0, 2, 32'h0));
    exp_q.push_back(mk_ev(1, 2, 32'h0));
    pkt0.delete();
    pkt1.delete();
  endtask

  // ---------------- stimulus ----------------
  task automatic hold(input int cycles);
    repeat (cycles) @(negedge clk);
  endtask

  // A bad stop bit leaves the line low on return.
  task automatic send_frame(input logic [7:0] v, input logic stop, input int gap);
    if (stop) model_good(v);
    else      model_bad();
    rxd = 1'b0;
    hold(BAUD);
    for (int i = 7; i >= 0; i--) begin
      rxd = v[i];
      hold(BAUD);
    end
    rxd = stop;
    hold(BAUD);
    if (stop) begin
      rxd = 1'b1;
      hold(gap);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    hold(3);
    vectors++;
    if ({data_out0, rx_byte0, v0, d0, fe0, busy0} !== 44'h0) begin
      errors++;
      $display("FAIL reset_msb: got data_out=%h rx_byte=%h pulses=%b%b%b busy=%b, expected all zero",
               data_out0, rx_byte0, v0, d0, fe0, busy0);
    end
    vectors++;
    if ({data_out1, rx_byte1, v1, d1, fe1, busy1} !== 44'h0) begin
      errors++;
      $display("FAIL reset_lsb: got data_out=%h rx_byte=%h pulses=%b%b%b busy=%b, expected all zero",
               data_out1, rx_byte1, v1, d1, fe1, busy1);
    end
    reset = 1'b0;
    hold(2 * BAUD);
    vectors++;
    if (busy0 !== 1'b0 || got_q.size() != 0) begin
      errors++;
      $display("FAIL reset_idle: got busy=%b events=%0d, expected busy=0 events=0", busy0, got_q.size());
    end
  endtask

  task automatic test_bit_order();
    send_frame(8'h80, 1'b1, 20);
    vectors++;
    if (rx_byte0 !== 8'h80) begin
      errors++;
      $display("FAIL bit_order_msb: got rx_byte=%h expected 80", rx_byte0);
    end
    vectors++;
    if (rx_byte1 !== 8'h01) begin
      errors++;
      $display("FAIL bit_order_lsb: got rx_byte=%h expected 01", rx_byte1);
    end
    for (int i = 0; i < 3; i++) send_frame(8'($urandom), 1'b1, int'($urandom_range(0, 30)));
    hold(2 * BAUD);
    vectors++;
    if (got_q.size() - got_rd != exp_q.size()) begin
      errors++;
      $display("FAIL bit_order event_count: got %0d expected %0d", got_q.size() - got_rd, exp_q.size());
    end
    foreach (exp_q[i]) begin
      if (got_rd < got_q.size()) begin
        vectors++;
        if (got_q[got_rd].dut !== exp_q[i].dut || got_q[got_rd].kind !== exp_q[i].kind ||
            got_q[got_rd].val !== exp_q[i].val) begin
          errors++;
          $display("FAIL bit_order event%0d: got dut%0d kind%0d %h expected dut%0d kind%0d %h", i,
                   got_q[got_rd].dut, got_q[got_rd].kind, got_q[got_rd].val,
                   exp_q[i].dut, exp_q[i].kind, exp_q[i].val);
        end
        got_rd++;
      end
    end
    got_rd = got_q.size();
    exp_q.delete();
  endtask

  task automatic test_loopback();
    logic [7:0] bytes [4] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    foreach (bytes[i]) send_frame(bytes[i], 1'b1, int'($urandom_range(0, 30)));
    hold(2 * BAUD);
    vectors++;
    if (got_q.size() - got_rd != exp_q.size()) begin
      errors++;
      $display("FAIL loopback event_count: got %0d expected %0d", got_q.size() - got_rd, exp_q.size());
    end
    foreach (exp_q[i]) begin
      if (got_rd < got_q.size()) begin
        vectors++;
        if (got_q[got_rd].dut !== exp_q[i].dut || got_q[got_rd].kind !== exp_q[i].kind ||
            got_q[got_rd].val !== exp_q[i].val) begin
          errors++;
          $display("FAIL loopback event%0d: got dut%0d kind%0d %h expected dut%0d kind%0d %h", i,
                   got_q[got_rd].dut, got_q[got_rd].kind, got_q[got_rd].val,
                   exp_q[i].dut, exp_q[i].kind, exp_q[i].val);
        end
        got_rd++;
      end
    end
    got_rd = got_q.size();
    exp_q.delete();
    vectors++;
    if (data_out0 !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL loopback data_out: got %h expected deadbeef", data_out0);
    end
  endtask

  task automatic test_glitch();
    send_frame(8'h12, 1'b1, 20);
    rxd = 1'b0;
    hold(4);
    rxd = 1'b1;
    hold(3 * BAUD);
    vectors++;
    if (busy0 !== 1'b0 || busy1 !== 1'b0) begin
      errors++;
      $display("FAIL glitch_idle: got busy=%b%b expected 00", busy0, busy1);
    end
    send_frame(8'h55, 1'b1, 10);
    send_frame(8'h66, 1'b1, 10);
    send_frame(8'h77, 1'b1, 10);
    hold(2 * BAUD);
    vectors++;
    if (got_q.size() - got_rd != exp_q.size()) begin
      errors++;
      $display("FAIL glitch event_count: got %0d expected %0d", got_q.size() - got_rd, exp_q.size());
    end
    foreach (exp_q[i]) begin
      if (got_rd < got_q.size()) begin
        vectors++;
        if (got_q[got_rd].dut !== exp_q[i].dut || got_q[got_rd].kind !== exp_q[i].kind ||
            got_q[got_rd].val !== exp_q[i].val) begin
          errors++;
          $display("FAIL glitch event%0d: got dut%0d kind%0d %h expected dut%0d kind%0d %h", i,
                   got_q[got_rd].dut, got_q[got_rd].kind, got_q[got_rd].val,
                   exp_q[i].dut, exp_q[i].kind, exp_q[i].val);
        end
        got_rd++;
      end
    end
    got_rd = got_q.size();
    exp_q.delete();
    vectors++;
    if (data_out0 !== 32'h12556677) begin
      errors++;
      $display("FAIL glitch data_out: got %h expected 12556677", data_out0);
    end
  endtask

  task automatic test_frame_error();
    send_frame(8'($urandom), 1'b1, 5);
    send_frame(8'($urandom), 1'b1, 5);
    send_frame(8'hA5, 1'b0, 0);
    hold(50);
    vectors++;
    if (busy0 !== 1'b1 || busy1 !== 1'b1) begin
      errors++;
      $display("FAIL frame_error_busy_low: got busy=%b%b expected 11", busy0, busy1);
    end
    rxd = 1'b1;
    hold(5);
    vectors++;
    if (busy0 !== 1'b0 || busy1 !== 1'b0) begin
      errors++;
      $display("FAIL frame_error_busy_release: got busy=%b%b expected 00", busy0, busy1);
    end
    send_frame(8'h11, 1'b1, 3);
    send_frame(8'h22, 1'b1, 3);
    send_frame(8'h33, 1'b1, 3);
    send_frame(8'h44, 1'b1, 3);
    hold(2 * BAUD);
    vectors++;
    if (got_q.size() - got_rd != exp_q.size()) begin
      errors++;
      $display("FAIL frame_error event_count: got %0d expected %0d", got_q.size() - got_rd, exp_q.size());
    end
    foreach (exp_q[i]) begin
      if (got_rd < got_q.size()) begin
        vectors++;
        if (got_q[got_rd].dut !== exp_q[i].dut || got_q[got_rd].kind !== exp_q[i].kind ||
            got_q[got_rd].val !== exp_q[i].val) begin
          errors++;
          $display("FAIL frame_error event%0d: got dut%0d kind%0d %h expected dut%0d kind%0d %h", i,
                   got_q[got_rd].dut, got_q[got_rd].kind, got_q[got_rd].val,
                   exp_q[i].dut, exp_q[i].kind, exp_q[i].val);
        end
        got_rd++;
      end
    end
    got_rd = got_q.size();
    exp_q.delete();
    vectors++;
    if (data_out0 !== 32'h11223344) begin
      errors++;
      $display("FAIL frame_error data_out: got %h expected 11223344", data_out0);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) send_frame(8'($urandom), 1'b1, (i == 3) ? BAUD : 0);
    hold(2 * BAUD);
    vectors++;
    if (got_q.size() - got_rd != exp_q.size()) begin
      errors++;
      $display("FAIL back_to_back event_count: got %0d expected %0d", got_q.size() - got_rd, exp_q.size());
    end
    foreach (exp_q[i]) begin
      if (got_rd < got_q.size()) begin
        vectors++;
        if (got_q[got_rd].dut !== exp_q[i].dut || got_q[got_rd].kind !== exp_q[i].kind ||
            got_q[got_rd].val !== exp_q[i].val) begin
          errors++;
          $display("FAIL back_to_back event%0d: got dut%0d kind%0d %h expected dut%0d kind%0d %h", i,
                   got_q[got_rd].dut, got_q[got_rd].kind, got_q[got_rd].val,
                   exp_q[i].dut, exp_q[i].kind, exp_q[i].val);
        end
        got_rd++;
      end
    end
    got_rd = got_q.size();
    exp_q.delete();
  endtask

  task automatic test_reset_mid();
    logic [7:0] bytes [4] = '{8'hCA, 8'hFE, 8'hF0, 8'h0D};
    send_frame(8'h99, 1'b1, 10);
    rxd = 1'b0;
    hold(BAUD);
    rxd = 1'b1;
    hold(BAUD);
    rxd = 1'b0;
    hold(BAUD / 2);
    reset = 1'b1;
    rxd = 1'b1;
    hold(1);
    vectors++;
    if ({data_out0, rx_byte0, v0, d0, fe0, busy0, data_out1, rx_byte1, busy1} !== 85'h0) begin
      errors++;
      $display("FAIL reset_mid: got data_out=%h/%h rx_byte=%h/%h pulses=%b%b%b busy=%b%b, expected all zero",
               data_out0, data_out1, rx_byte0, rx_byte1, v0, d0, fe0, busy0, busy1);
    end
    reset = 1'b0;
    pkt0.delete();
    pkt1.delete();
    hold(3 * BAUD);
    foreach (bytes[i]) send_frame(bytes[i], 1'b1, int'($urandom_range(0, 20)));
    hold(2 * BAUD);
    vectors++;
    if (got_q.size() - got_rd != exp_q.size()) begin
      errors++;
      $display("FAIL reset_mid event_count: got %0d expected %0d", got_q.size() - got_rd, exp_q.size());
    end
    foreach (exp_q[i]) begin
      if (got_rd < got_q.size()) begin
        vectors++;
        if (got_q[got_rd].dut !== exp_q[i].dut || got_q[got_rd].kind !== exp_q[i].kind ||
            got_q[got_rd].val !== exp_q[i].val) begin
          errors++;
          $display("FAIL reset_mid event%0d: got dut%0d kind%0d %h expected dut%0d kind%0d %h", i,
                   got_q[got_rd].dut, got_q[got_rd].kind, got_q[got_rd].val,
                   exp_q[i].dut, exp_q[i].kind, exp_q[i].val);
        end
        got_rd++;
      end
    end
    got_rd = got_q.size();
    exp_q.delete();
    vectors++;
    if (data_out0 !== 32'hCAFEF00D) begin
      errors++;
      $display("FAIL reset_mid data_out: got %h expected cafef00d", data_out0);
    end
  endtask

  task automatic test_random_packets();
    for (int i = 0; i < 3 * NB; i++) send_frame(8'($urandom), 1'b1, int'($urandom_range(0, 40)));
    hold(2 * BAUD);
    vectors++;
    if (got_q.size() - got_rd != exp_q.size()) begin
      errors++;
      $display("FAIL random event_count: got %0d expected %0d", got_q.size() - got_rd, exp_q.size());
    end
    foreach (exp_q[i]) begin
      if (got_rd < got_q.size()) begin
        vectors++;
        if (got_q[got_rd].dut !== exp_q[i].dut || got_q[got_rd].kind !== exp_q[i].kind ||
            got_q[got_rd].val !== exp_q[i].val) begin
          errors++;
          $display("FAIL random event%0d: got dut%0d kind%0d %h expected dut%0d kind%0d %h", i,
                   got_q[got_rd].dut, got_q[got_rd].kind, got_q[got_rd].val,
                   exp_q[i].dut, exp_q[i].kind, exp_q[i].val);
        end
        got_rd++;
      end
    end
    got_rd = got_q.size();
    exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_bit_order();
    test_loopback();
    test_glitch();
    test_frame_error();
    test_back_to_back();
    test_reset_mid();
    test_random_packets();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
